// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared FSM encoding and frame constants for the boot loader
package imem_boot_loader_pkg;

    localparam int         DEFAULT_ADDR_WIDTH = 8;
    localparam logic [7:0] MAGIC_DEFAULT      = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

    // A frame may fill the memory exactly; anything larger is rejected.
    function automatic logic len_exceeds(input logic [15:0] n, input int aw);
        return {16'd0, n} > (32'd1 << aw);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte-stream input and instMem write port of the boot loader
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_packer.sv
// rtl/imem_boot_loader_packer.sv - assembles little-endian payload bytes into 32-bit words
module imem_boot_loader_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  lane_q;
    logic [23:0] shift_q;

    // The fourth byte is combined directly so the word is available on its accept edge.
    assign word_done = byte_valid && (lane_q == 2'd3);
    assign word      = {byte_data, shift_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
        end else if (clr) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
        end else if (byte_valid) begin
            lane_q  <= lane_q + 2'd1;
            shift_q <= {byte_data, shift_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads instMem from a framed byte stream and gates the CPU reset
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [7:0] MAGIC      = MAGIC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reload,
    output logic               cpu_rst,
    output logic               done,
    output logic               error,
    imem_boot_loader_if.master bus
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    boot_state_t           state_q, state_d;
    logic                  armed_q;
    logic [7:0]            len_lo_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   word_cnt_q;
    logic [7:0]            csum_q;
    logic                  accept;
    logic                  byte_valid;
    logic                  clr;
    logic                  word_done;
    logic                  last_word;
    logic [31:0]           word;
    logic [15:0]           len_word;

    // armed_q keeps in_ready low for the first cycle out of reset.
    assign bus.in_ready = armed_q && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign accept       = bus.in_valid && bus.in_ready;
    assign byte_valid   = accept && (state_q == ST_DATA);
    assign len_word     = {bus.in_data, len_lo_q};
    assign last_word    = (word_cnt_q + CNT_ONE) == len_q;
    assign clr          = (state_d == ST_IDLE);

    imem_boot_loader_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .byte_valid (byte_valid),
        .byte_data  (bus.in_data),
        .word_done  (word_done),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cpu_rst = 1'b1;
        done    = 1'b0;
        error   = 1'b0;
        case (state_q)
            ST_IDLE:   if (accept && bus.in_data == MAGIC) state_d = ST_LEN_LO;
            ST_LEN_LO: if (accept) state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (accept) begin
                    if (len_exceeds(len_word, ADDR_WIDTH)) state_d = ST_ERROR;
                    else if (len_word == 16'd0)            state_d = ST_CHECK;
                    else                                   state_d = ST_DATA;
                end
            end
            ST_DATA:   if (word_done && last_word) state_d = ST_CHECK;
            ST_CHECK:  if (accept) state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERROR;
            ST_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (reload) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (reload) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo_q   <= 8'd0;
            len_q      <= '0;
            word_cnt_q <= '0;
            csum_q     <= 8'd0;
        end else begin
            if (state_q == ST_LEN_LO && accept) len_lo_q <= bus.in_data;
            // Only the low ADDR_WIDTH+1 bits matter once the oversize check has passed.
            if (state_q == ST_LEN_HI && accept) len_q <= len_word[ADDR_WIDTH:0];
            if (clr) begin
                word_cnt_q <= '0;
                csum_q     <= 8'd0;
            end else begin
                if (word_done)  word_cnt_q <= word_cnt_q + CNT_ONE;
                if (byte_valid) csum_q     <= csum_q ^ bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= 32'd0;
        end else begin
            bus.imem_we <= word_done;
            if (word_done) begin
                bus.imem_addr  <= word_cnt_q[ADDR_WIDTH-1:0];
                bus.imem_wdata <= word;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized frame bench for imem_boot_loader with a frame-level model
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic reload = 1'b0;
    logic cpu_rst, done, error;

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW), .MAGIC(MAGIC_DEFAULT)) dut (
        .clk     (clk),
        .rst     (rst),
        .reload  (reload),
        .cpu_rst (cpu_rst),
        .done    (done),
        .error   (error),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [7:0]    frame[$];
    logic [31:0]   exp_words[$];

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int t;
        while ($urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input bit check_last);
        for (int i = 0; i < frame.size(); i++) begin
            if (check_last && i == frame.size() - 1) chk("done_early", {31'd0, done}, 32'd0);
            send_byte(frame[i], gap_pct);
        end
        if (check_last) begin
            chk("done_latency", {31'd0, done}, 32'd1);
            chk("cpu_rst_latency", {31'd0, cpu_rst}, 32'd0);
        end
    endtask

    // Frame model: payload words go to consecutive addresses, checksum is XOR of payload bytes.
    task automatic make_frame(input int n, input bit bad_ck);
        logic [7:0]  ck;
        logic [31:0] w;
        ck = 8'd0;
        frame.delete();
        exp_words.delete();
        frame.push_back(MAGIC_DEFAULT);
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            exp_words.push_back(w);
            for (int j = 0; j < 4; j++) begin
                frame.push_back(w[8*j +: 8]);
                ck ^= w[8*j +: 8];
            end
        end
        frame.push_back(bad_ck ? ~ck : ck);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic expect_result(input string tag, input bit exp_done);
        repeat (2) @(negedge clk);
        chk({tag, "_nwr"}, wr_data.size(), exp_words.size());
        for (int k = 0; k < exp_words.size() && k < wr_data.size(); k++) begin
            chk({tag, "_addr"}, {24'd0, wr_addr[k]}, k);
            chk({tag, "_data"}, wr_data[k], exp_words[k]);
        end
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, !exp_done});
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, !exp_done});
        chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    endtask

    task automatic do_reload(input string tag);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk({tag, "_rl_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_rl_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_rl_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        chk({tag, "_rl_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic load_fixed();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
        exp_words = '{32'h0050_0013, 32'h0010_0093};
    endtask

    initial begin
        int n, gap;
        bit bad;
        logic [7:0] nb;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        repeat (3) @(negedge clk);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_we", {31'd0, bus.imem_we}, 32'd0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_ready_low", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ready_high", {31'd0, bus.in_ready}, 32'd1);

        clear_log();
        load_fixed();
        send_frame(0, 1'b1);
        expect_result("good", 1'b1);
        do_reload("good");

        clear_log();
        load_fixed();
        frame[frame.size() - 1] = 8'h00;
        send_frame(0, 1'b0);
        expect_result("badck", 1'b0);
        do_reload("badck");

        clear_log();
        frame = '{8'hA5, 8'h01, 8'h01};
        exp_words.delete();
        send_frame(0, 1'b0);
        expect_result("oversize", 1'b0);
        do_reload("oversize");

        clear_log();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        exp_words.delete();
        send_frame(0, 1'b0);
        expect_result("empty", 1'b1);
        do_reload("empty");

        clear_log();
        load_fixed();
        frame.push_front(8'hFF);
        frame.push_front(8'h00);
        send_frame(40, 1'b0);
        expect_result("noise", 1'b1);
        do_reload("noise");

        clear_log();
        load_fixed();
        for (int i = 0; i < 5; i++) send_byte(frame[i], 0);
        rst = 1'b0;
        #1;
        chk("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("midrst_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_nwr", wr_data.size(), 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        send_frame(20, 1'b0);
        expect_result("midrst_reload", 1'b1);
        do_reload("midrst");

        for (int it = 0; it < 20; it++) begin
            n   = $urandom_range(0, 6);
            bad = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 50);
            clear_log();
            make_frame(n, bad);
            for (int j = $urandom_range(0, 3); j > 0; j--) begin
                nb = 8'($urandom);
                if (nb == MAGIC_DEFAULT) nb = 8'h5A;
                frame.push_front(nb);
            end
            send_frame(gap, 1'b0);
            expect_result("rand", !bad);
            do_reload("rand");
        end

        clear_log();
        make_frame(1 << AW, 1'b0);
        send_frame(0, 1'b0);
        expect_result("maxlen", 1'b1);
        do_reload("maxlen");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
